// File: rtl/crc16_sched.sv
// Round-robin scheduler sharing one nibble-serial CRC16 (poly 0x1021) engine
// between NCH requesters, each with its own 16-bit running context.
module crc16_sched #(
    parameter int NCH = 4,
    parameter int IDW = $clog2(NCH)
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic [15:0]        init_i,
    input  logic [15:0]        xorv_i,
    input  logic [NCH-1:0]     clr_i,
    input  logic [NCH-1:0]     req_valid_i,
    input  logic [NCH*16-1:0]  req_data_i,
    output logic [NCH-1:0]     req_ready_o,
    output logic [NCH*16-1:0]  crc_o,
    output logic               busy_o,
    output logic [IDW-1:0]     gnt_id_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT1 = 3'd1,
        SHIFT2 = 3'd2,
        SHIFT3 = 3'd3,
        SHIFT4 = 3'd4
    } state_t;

    state_t         state_q;
    logic [15:0]    ctx_q [NCH];
    logic [15:0]    data_q;
    logic [IDW-1:0] gnt_q;
    logic [IDW-1:0] rr_q;

    logic [NCH-1:0] elig;
    logic           found;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] rr_d;
    logic [3:0]     nib;
    logic [15:0]    shift_d;
    logic [15:0]    req_lane [NCH];

    // Four MSB-first bit steps of the 0x1021 LFSR per nibble.
    function automatic logic [15:0] crc_nib(input logic [15:0] c, input logic [3:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 3; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // A channel being cleared this cycle is not eligible; the next valid one wins.
    always_comb begin
        elig  = req_valid_i & ~clr_i;
        found = 1'b0;
        pick  = '0;
        for (int off = NCH - 1; off >= 0; off--) begin
            int idx;
            idx = (int'(rr_q) + off) % NCH;
            if (elig[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    always_comb begin
        case (state_q)
            SHIFT1:  nib = data_q[3:0];
            SHIFT2:  nib = data_q[7:4];
            SHIFT3:  nib = data_q[11:8];
            SHIFT4:  nib = data_q[15:12];
            default: nib = data_q[3:0];
        endcase
        shift_d = crc_nib(ctx_q[gnt_q], nib);
        rr_d    = (gnt_q == IDW'(NCH - 1)) ? '0 : gnt_q + IDW'(1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_lane
            assign req_lane[gi]            = req_data_i[16*gi +: 16];
            assign crc_o[16*gi +: 16]      = ctx_q[gi] ^ xorv_i;
            assign req_ready_o[gi]         = (state_q == IDLE) && found && (pick == IDW'(gi));
        end
    endgenerate

    assign busy_o   = (state_q != IDLE);
    assign gnt_id_o = gnt_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            rr_q    <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
            for (int k = 0; k < NCH; k++) ctx_q[k] <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (clr_i[k])
                    ctx_q[k] <= init_i;
                else if (state_q != IDLE && gnt_q == IDW'(k))
                    ctx_q[k] <= shift_d;
            end
            case (state_q)
                IDLE: begin
                    if (found) begin
                        data_q  <= req_lane[pick];
                        gnt_q   <= pick;
                        state_q <= SHIFT1;
                    end
                end
                SHIFT1: begin
                    state_q <= clr_i[gnt_q] ? IDLE : SHIFT2;
                    if (clr_i[gnt_q]) rr_q <= rr_d;
                end
                SHIFT2: begin
                    state_q <= clr_i[gnt_q] ? IDLE : SHIFT3;
                    if (clr_i[gnt_q]) rr_q <= rr_d;
                end
                SHIFT3: begin
                    state_q <= clr_i[gnt_q] ? IDLE : SHIFT4;
                    if (clr_i[gnt_q]) rr_q <= rr_d;
                end
                default: begin
                    state_q <= IDLE;
                    rr_q    <= rr_d;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc16_sched.sv
// Directed bench for crc16_sched: CRC math, final XOR, round-robin order,
// pointer wrap, clear collisions and asynchronous reset.
module tb_crc16_sched;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [15:0] init_i, xorv_i;
    logic [3:0]  clr_i, req_valid_i, req_ready_o;
    logic [63:0] req_data_i, crc_o;
    logic        busy_o;
    logic [1:0]  gnt_id_o;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] mdl [4];

    crc16_sched #(.NCH(4)) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .init_i      (init_i),
        .xorv_i      (xorv_i),
        .clr_i       (clr_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .crc_o       (crc_o),
        .busy_o      (busy_o),
        .gnt_id_o    (gnt_id_o)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit stream order: nibble 0 first, each nibble MSB first.
    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [15:0] w);
        logic fb;
        for (int b = 0; b < 16; b++) begin
            fb = c[15] ^ w[4*(b/4) + 3 - (b%4)];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    function automatic logic [63:0] lanes();
        return {mdl[3] ^ xorv_i, mdl[2] ^ xorv_i, mdl[1] ^ xorv_i, mdl[0] ^ xorv_i};
    endfunction

    task automatic step();
        @(posedge pclk); #1;
    endtask

    // Single-channel word: handshake, four busy cycles, then result check.
    task automatic xfer(input int ch, input logic [15:0] w);
        req_data_i[16*ch +: 16] = w;
        req_valid_i = 4'(1 << ch);
        #1;
        chk("xfer_ready", 64'(req_ready_o), 64'(1) << ch);
        step();
        req_valid_i = '0;
        mdl[ch] = ref_crc(mdl[ch], w);
        $display("txn ch=%0d data=%h ctx=%h", ch, w, mdl[ch]);
        for (int c = 0; c < 4; c++) begin
            chk("xfer_busy", 64'(busy_o), 64'(1));
            chk("xfer_noready", 64'(req_ready_o), 64'(0));
            step();
        end
        chk("xfer_idle", 64'(busy_o), 64'(0));
        chk("xfer_gnt", 64'(gnt_id_o), 64'(ch));
        chk("xfer_crc", crc_o, lanes());
    endtask

    initial begin
        presetn = 1'b0; init_i = '0; xorv_i = 16'h1234; clr_i = '0;
        req_valid_i = '0; req_data_i = '0;
        for (int k = 0; k < 4; k++) mdl[k] = '0;
        #3;
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_ready", 64'(req_ready_o), 64'(0));
        chk("rst_gnt", 64'(gnt_id_o), 64'(0));
        chk("rst_crc", crc_o, {4{16'h1234}});
        step();
        presetn = 1'b1; xorv_i = '0;

        // Single word 0x0001 from init 0
        clr_i = 4'h1; step(); clr_i = '0;
        xfer(0, 16'h0001);
        chk("tp1_lane0", 64'(crc_o[15:0]), 64'h0373);
        chk("tp1_others", 64'(crc_o[63:16]), 64'h0);

        // Final XOR, and a zero word leaves a zero context unchanged
        xorv_i = 16'hFFFF; #1;
        chk("xor_lanes", crc_o, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFC8C});
        xfer(1, 16'h0000);
        chk("xor_zero", 64'(crc_o[31:16]), 64'hFFFF);
        xorv_i = '0;
        xfer(3, 16'h00A5);

        // Round-robin with all channels valid
        init_i = 16'hFFFF; clr_i = 4'hF; step(); clr_i = '0;
        for (int k = 0; k < 4; k++) mdl[k] = 16'hFFFF;
        chk("rr_cleared", crc_o, {4{16'hFFFF}});
        req_data_i = {16'hD00D, 16'hC0DE, 16'hBEEF, 16'h1234};
        req_valid_i = 4'hF;
        for (int n = 0; n < 5; n++) begin
            int g;
            g = n % 4;
            #1;
            chk("rr_ready", 64'(req_ready_o), 64'(1) << g);
            step();
            if (n == 4) req_valid_i = '0;
            mdl[g] = ref_crc(mdl[g], req_data_i[16*g +: 16]);
            $display("txn ch=%0d data=%h ctx=%h", g, req_data_i[16*g +: 16], mdl[g]);
            chk("rr_gnt", 64'(gnt_id_o), 64'(g));
            for (int c = 0; c < 4; c++) begin
                chk("rr_gap", 64'(req_ready_o), 64'(0));
                step();
            end
        end
        chk("rr_crc", crc_o, lanes());

        // Pointer wrap: pointer at 3, only ch1 valid; next search starts at 2
        xfer(2, 16'h5A5A);
        xfer(1, 16'h0F0F);
        req_data_i[15:0] = 16'h7777; req_data_i[47:32] = 16'h3C3C;
        req_valid_i = 4'b0101; #1;
        chk("wrap_next", 64'(req_ready_o), 64'b0100);
        step(); req_valid_i = '0;
        mdl[2] = ref_crc(mdl[2], 16'h3C3C);
        $display("txn ch=2 data=3c3c ctx=%h", mdl[2]);
        repeat (4) step();
        chk("wrap_crc", crc_o, lanes());

        // Clear of the in-flight channel during SHIFT2 aborts and advances pointer
        xfer(0, 16'h8001);
        req_data_i[47:32] = 16'h9999; req_valid_i = 4'b0100; #1;
        chk("clr_ready2", 64'(req_ready_o), 64'b0100);
        step();
        req_data_i[31:16] = 16'h1111; req_data_i[63:48] = 16'h2468;
        req_valid_i = 4'b1010;
        chk("clr_shift1", 64'(req_ready_o), 64'(0));
        step();
        init_i = 16'hABCD; clr_i = 4'b0100;
        chk("clr_busy", 64'(busy_o), 64'(1));
        step();
        clr_i = '0; mdl[2] = 16'hABCD; #1;
        chk("clr_idle", 64'(busy_o), 64'(0));
        chk("clr_ctx2", 64'(crc_o[47:32]), 64'hABCD);
        chk("clr_next3", 64'(req_ready_o), 64'b1000);
        step(); req_valid_i = '0;
        mdl[3] = ref_crc(mdl[3], 16'h2468);
        $display("txn ch=3 data=2468 ctx=%h", mdl[3]);
        repeat (4) step();
        chk("clr_crc", crc_o, lanes());

        // Clear and valid on the same channel in IDLE
        init_i = 16'h4321; clr_i = 4'b0010; req_valid_i = 4'b0110; #1;
        chk("clrv_ready", 64'(req_ready_o), 64'b0100);
        step(); clr_i = '0; req_valid_i = '0;
        mdl[1] = 16'h4321;
        mdl[2] = ref_crc(mdl[2], 16'h9999);
        $display("txn ch=2 data=9999 ctx=%h", mdl[2]);
        repeat (4) step();
        chk("clrv_crc", crc_o, lanes());

        // Asynchronous reset in SHIFT3
        req_data_i[47:32] = 16'hFACE; req_valid_i = 4'b0100; #1;
        step(); req_valid_i = '0;
        step(); step();
        chk("ar_busy_pre", 64'(busy_o), 64'(1));
        #2 presetn = 1'b0; #1;
        chk("ar_busy", 64'(busy_o), 64'(0));
        chk("ar_ready", 64'(req_ready_o), 64'(0));
        chk("ar_gnt", 64'(gnt_id_o), 64'(0));
        chk("ar_crc", crc_o, 64'h0);
        @(negedge pclk); presetn = 1'b1;
        for (int k = 0; k < 4; k++) mdl[k] = '0;
        step();
        req_valid_i = 4'hF; #1;
        chk("ar_ptr", 64'(req_ready_o), 64'b0001);
        step(); req_valid_i = '0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
